mem_line_resp: RTL and testbench

Memory-side responder for the 128-bit line interface driven by the data and instruction caches. It accepts one line read or line write per handshake, models a fixed access latency, and answers with a single-cycle `mem_ready` pulse. It sits below the caches in system simulation and FPGA builds as the backing line store, and also checks the initiator's handshake discipline.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_line_array.sv | 40 ++++
 rtl/mem_line_resp.sv | 113 +++++++++++
 tb/tb_mem_line_resp.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared widths and encodings for the 128-bit cache line interface.
// The caches and the memory-side responder both import these definitions.
package mem_pkg;

    localparam int MEM_ADDR_W = 28;
    localparam int MEM_LINE_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic {
        CMD_RD = 1'b0,
        CMD_WR = 1'b1
    } cmd_t;

endpackage

// File: rtl/mem_line_array.sv
// Line store: 2^DEPTH_LOG2 x 128-bit lines, one synchronous write port and
// one registered read port; the read register holds until the next read.
module mem_line_array
    import mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_idx,
    input  logic [MEM_LINE_W-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic [MEM_LINE_W-1:0] rd_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [MEM_LINE_W-1:0] lines [DEPTH];

    // NOTE: clearing every line on reset makes this a register file rather than
    // a block RAM; it is kept because reset must observably zero the store.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                lines[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                lines[wr_idx] <= wr_data;
            end
            if (rd_en) begin
                rd_data <= lines[rd_idx];
            end
        end
    end

endmodule

// File: rtl/mem_line_resp.sv
// Memory-side line responder: one read or write per handshake, fixed latency,
// single-cycle mem_ready pulse and a sticky handshake-violation flag.
module mem_line_resp
    import mem_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [MEM_LINE_W-1:0] mem_wdata,
    output logic [MEM_LINE_W-1:0] mem_rdata,
    output logic                  mem_ready,
    output logic                  proto_err
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t                  state;
    logic [3:0]              cnt;
    cmd_t                    cmd_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [MEM_LINE_W-1:0]   wdata_q;

    logic                    req;
    cmd_t                    req_cmd;
    logic                    accept;
    logic                    to_done;
    logic                    rd_en;
    logic [DEPTH_LOG2-1:0]   rd_idx;
    logic                    wr_en;

    // Upper address bits alias onto the same lines by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[MEM_ADDR_W-1:DEPTH_LOG2];

    // NOTE: every signal gets a default before any branch so no path infers a latch.
    always_comb begin
        req     = mem_read | mem_write;
        req_cmd = mem_write ? CMD_WR : CMD_RD;
        accept  = (state == IDLE) && req;
        to_done = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == 4'd1));
        rd_idx  = idx_q;
        rd_en   = 1'b0;
        if (state == IDLE) begin
            // With LATENCY==1 the line must be fetched on the accept edge itself.
            rd_idx = mem_addr[DEPTH_LOG2-1:0];
            rd_en  = to_done && (req_cmd == CMD_RD);
        end else begin
            rd_en  = to_done && (cmd_q == CMD_RD);
        end
        wr_en = (state == DONE) && (cmd_q == CMD_WR);
    end

    // NOTE: state registers use non-blocking assignment so every update in this
    // block sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd_q     <= CMD_RD;
            idx_q     <= '0;
            wdata_q   <= '0;
            mem_ready <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            mem_ready <= to_done;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd_q   <= req_cmd;
                        idx_q   <= mem_addr[DEPTH_LOG2-1:0];
                        wdata_q <= mem_wdata;
                        cnt     <= CNT_LOAD;
                        state   <= (LATENCY == 1) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (!req || (req_cmd != cmd_q)) begin
                        proto_err <= 1'b1;
                    end
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mem_line_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_idx  (idx_q),
        .wr_data (wdata_q),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (mem_rdata)
    );

endmodule

// File: tb/tb_mem_line_resp.sv
// Directed bench for mem_line_resp: a LATENCY=4 instance for the main sequence
// and a LATENCY=1 instance for back-to-back completions.
module tb_mem_line_resp;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic                  mem_read = 1'b0;
    logic                  mem_write = 1'b0;
    logic [MEM_ADDR_W-1:0] mem_addr = '0;
    logic [MEM_LINE_W-1:0] mem_wdata = '0;
    logic [MEM_LINE_W-1:0] mem_rdata;
    logic                  mem_ready;
    logic                  proto_err;

    logic                  mem_read_1 = 1'b0;
    logic                  mem_write_1 = 1'b0;
    logic [MEM_ADDR_W-1:0] mem_addr_1 = '0;
    logic [MEM_LINE_W-1:0] mem_wdata_1 = '0;
    logic [MEM_LINE_W-1:0] mem_rdata_1;
    logic                  mem_ready_1;
    logic                  proto_err_1;

    int total = 0;
    int bad = 0;

    localparam logic [127:0] DATA_D = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] DATA_A = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] DATA_X = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    localparam logic [127:0] DATA_W = 128'h00000001_00000002_00000003_00000004;

    always #5 clk = ~clk;

    mem_line_resp #(.LATENCY(4), .DEPTH_LOG2(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .proto_err (proto_err)
    );

    mem_line_resp #(.LATENCY(1), .DEPTH_LOG2(6)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read_1),
        .mem_write (mem_write_1),
        .mem_addr  (mem_addr_1),
        .mem_wdata (mem_wdata_1),
        .mem_rdata (mem_rdata_1),
        .mem_ready (mem_ready_1),
        .proto_err (proto_err_1)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [27:0] a, input logic [127:0] d);
        mem_write = wr;
        mem_read  = rd;
        mem_addr  = a;
        mem_wdata = d;
    endtask

    // Steps n cycles; mem_ready must be low until exactly the n-th.
    task automatic wait_ready(input int n, input string tag);
        for (int k = 1; k <= n; k++) begin
            step();
            check($sformatf("%s_c%0d", tag, k), 128'(mem_ready), 128'(k == n));
        end
    endtask

    task automatic idle(input string tag);
        drive(1'b0, 1'b0, '0, '0);
        step();
        check(tag, 128'(mem_ready), 128'(0));
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_ready", 128'(mem_ready), 128'(0));
        check("rst_rdata", mem_rdata, 128'(0));
        check("rst_perr", 128'(proto_err), 128'(0));

        // Read of line 5 after reset returns 0 exactly at T+4
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 28'h0000005, '0);
        wait_ready(4, "rd5");
        check("rd5_data", mem_rdata, 128'(0));
        check("rd5_perr", 128'(proto_err), 128'(0));
        idle("rd5_after");

        // Write line 3 then read it back
        drive(1'b1, 1'b0, 28'h0000003, DATA_D);
        wait_ready(4, "wr3");
        check("wr3_rdata_hold", mem_rdata, 128'(0));
        idle("wr3_after");
        drive(1'b0, 1'b1, 28'h0000003, '0);
        wait_ready(4, "rd3");
        check("rd3_data", mem_rdata, DATA_D);
        idle("rd3_after");

        // Writeback of line 7, refill of line B requested in the DONE cycle
        drive(1'b1, 1'b0, 28'h0000007, DATA_A);
        wait_ready(4, "wb7");
        drive(1'b0, 1'b1, 28'h000000B, DATA_X);
        wait_ready(5, "refillB");
        check("refillB_data", mem_rdata, 128'(0));
        idle("refillB_after");
        drive(1'b0, 1'b1, 28'h0000007, '0);
        wait_ready(4, "rd7");
        check("rd7_data", mem_rdata, DATA_A);
        idle("rd7_after");

        // Both requests high: the write wins, mem_rdata is untouched
        drive(1'b1, 1'b1, 28'h0000002, 128'h1);
        wait_ready(4, "both2");
        check("both2_rdata_hold", mem_rdata, DATA_A);
        idle("both2_after");
        drive(1'b0, 1'b1, 28'h0000002, '0);
        wait_ready(4, "rd2");
        check("rd2_data", mem_rdata, 128'h1);
        idle("rd2_after");

        // Storage wrap index and its alias hit the same line
        drive(1'b1, 1'b0, 28'h000003F, DATA_X);
        wait_ready(4, "wr3f");
        idle("wr3f_after");
        drive(1'b0, 1'b1, 28'h800007F, '0);
        wait_ready(4, "rd7f");
        check("rd7f_alias_data", mem_rdata, DATA_X);
        idle("rd7f_after");

        // Dropping mem_read in WAIT sets the sticky error; completion is unchanged
        drive(1'b0, 1'b1, 28'h0000004, '0);
        step();
        check("perr_c1_ready", 128'(mem_ready), 128'(0));
        check("perr_c1", 128'(proto_err), 128'(0));
        drive(1'b0, 1'b0, 28'h0000004, '0);
        step();
        check("perr_c2", 128'(proto_err), 128'(1));
        check("perr_c2_ready", 128'(mem_ready), 128'(0));
        step();
        check("perr_c3_ready", 128'(mem_ready), 128'(0));
        step();
        check("perr_c4_ready", 128'(mem_ready), 128'(1));
        idle("perr_after");
        step();
        check("perr_sticky", 128'(proto_err), 128'(1));

        // LATENCY=1: write line A, then a held read completes every other cycle
        mem_write_1 = 1'b1;
        mem_addr_1  = 28'h000000A;
        mem_wdata_1 = DATA_W;
        step();
        check("l1_wr_ready", 128'(mem_ready_1), 128'(1));
        mem_write_1 = 1'b0;
        mem_read_1  = 1'b1;
        mem_wdata_1 = '0;
        step();
        check("l1_rd_idle", 128'(mem_ready_1), 128'(0));
        step();
        check("l1_rd_ready1", 128'(mem_ready_1), 128'(1));
        check("l1_rd_data", mem_rdata_1, DATA_W);
        step();
        check("l1_rd_gap", 128'(mem_ready_1), 128'(0));
        mem_addr_1 = 28'h0000001;
        step();
        check("l1_rd_ready2", 128'(mem_ready_1), 128'(1));
        check("l1_rd_data2", mem_rdata_1, 128'(0));
        mem_read_1 = 1'b0;
        step();
        check("l1_after", 128'(mem_ready_1), 128'(0));
        check("l1_perr", 128'(proto_err_1), 128'(0));

        // Reset in WAIT of a write drops it and clears the store
        drive(1'b1, 1'b0, 28'h0000009, DATA_D);
        step();
        step();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        step();
        check("rstw_ready", 128'(mem_ready), 128'(0));
        check("rstw_rdata", mem_rdata, 128'(0));
        check("rstw_perr", 128'(proto_err), 128'(0));
        check("rstw_rdata_l1", mem_rdata_1, 128'(0));
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("rstw_quiet_c%0d", k), 128'(mem_ready), 128'(0));
        end
        drive(1'b0, 1'b1, 28'h0000009, '0);
        wait_ready(4, "rd9");
        check("rd9_data", mem_rdata, 128'(0));
        idle("rd9_after");
        drive(1'b0, 1'b1, 28'h0000003, '0);
        wait_ready(4, "rd3_cleared");
        check("rd3_cleared_data", mem_rdata, 128'(0));
        idle("rd3_cleared_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
